// File: rtl/aes_ks_pkg.sv
// Shared types, constants and helpers for the iterative AES-128 key schedule.
package aes_ks_pkg;

  localparam int unsigned KEY_W  = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned RND_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } ks_state_e;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1b;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/key_sched_sbox.sv
// Combinational AES forward S-box lookup for one byte.
module key_sched_sbox
  import aes_ks_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] sub_c
);

  assign sub_c = SBOX[in_byte];

endmodule

// File: rtl/aes_key_sched_iter.sv
// Iterative AES-128 key expansion: one round key per clock into a NUM_RK-entry bank.
// Optional round-key stream port enabled by defining KEY_SCHED_STREAM_EN.
module aes_key_sched_iter
  import aes_ks_pkg::*;
#(
  parameter int unsigned NUM_RK = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [KEY_W-1:0]        key_in,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_RK*KEY_W-1:0] rk_bus
`ifdef KEY_SCHED_STREAM_EN
  ,
  output logic [KEY_W-1:0]        rk_stream,
  output logic                    rk_stream_v,
  output logic [RND_W-1:0]        rk_stream_i
`endif
);

  ks_state_e               state_q, state_d;
  logic [KEY_W-1:0]        w_q, w_d;
  logic [RND_W-1:0]        rnd_q, rnd_d;
  logic [7:0]              rcon_q, rcon_d;
  logic [NUM_RK*KEY_W-1:0] bank_q, bank_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
`ifdef KEY_SCHED_STREAM_EN
  logic [KEY_W-1:0]        stream_q, stream_d;
  logic                    stream_v_q, stream_v_d;
  logic [RND_W-1:0]        stream_i_q, stream_i_d;
`endif

  logic [WORD_W-1:0] rot_w;
  logic [WORD_W-1:0] sub_w;
  logic [WORD_W-1:0] t_w;
  logic [WORD_W-1:0] w0_n, w1_n, w2_n, w3_n;
  logic [KEY_W-1:0]  w_next;

  // RotWord on w3, then SubWord through four byte lookups.
  assign rot_w = {w_q[23:0], w_q[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    key_sched_sbox u_sbox (
      .in_byte (rot_w[WORD_W-1-8*g -: 8]),
      .sub_c   (sub_w[WORD_W-1-8*g -: 8])
    );
  end

  assign t_w    = sub_w ^ {rcon_q, 24'h0};
  assign w0_n   = w_q[127:96] ^ t_w;
  assign w1_n   = w_q[95:64]  ^ w0_n;
  assign w2_n   = w_q[63:32]  ^ w1_n;
  assign w3_n   = w_q[31:0]   ^ w2_n;
  assign w_next = {w0_n, w1_n, w2_n, w3_n};

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    rnd_d   = rnd_q;
    rcon_d  = rcon_q;
    bank_d  = bank_q;
`ifdef KEY_SCHED_STREAM_EN
    stream_d   = stream_q;
    stream_v_d = 1'b0;
    stream_i_d = stream_i_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          w_d     = key_in;
          rnd_d   = RND_W'(1);
          rcon_d  = RCON_INIT;
          state_d = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        w_d    = w_next;
        rcon_d = xtime(rcon_q);
        for (int unsigned i = 0; i < NUM_RK; i++) begin
          if (rnd_q == RND_W'(i + 1)) bank_d[i*KEY_W +: KEY_W] = w_next;
        end
`ifdef KEY_SCHED_STREAM_EN
        stream_d   = w_next;
        stream_v_d = 1'b1;
        stream_i_d = rnd_q;
`endif
        if (rnd_q == RND_W'(NUM_RK)) state_d = ST_DONE;
        else                         rnd_d   = rnd_q + RND_W'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Status flags are registered copies of the state being entered.
    busy_d = (state_d == ST_EXPAND);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      rnd_q   <= '0;
      rcon_q  <= RCON_INIT;
      bank_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef KEY_SCHED_STREAM_EN
      stream_q   <= '0;
      stream_v_q <= 1'b0;
      stream_i_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      rnd_q   <= rnd_d;
      rcon_q  <= rcon_d;
      bank_q  <= bank_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef KEY_SCHED_STREAM_EN
      stream_q   <= stream_d;
      stream_v_q <= stream_v_d;
      stream_i_q <= stream_i_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign rk_bus = bank_q;
`ifdef KEY_SCHED_STREAM_EN
  assign rk_stream   = stream_q;
  assign rk_stream_v = stream_v_q;
  assign rk_stream_i = stream_i_q;
`endif

endmodule

// File: tb/tb_aes_key_sched_iter.sv
// Bench for aes_key_sched_iter: known-answer table, random keys against a GF(2^8) reference model,
// start/reset corner sequences, and a NUM_RK=8 instance. Stream checks when KEY_SCHED_STREAM_EN is defined.
module tb_aes_key_sched_iter;

  typedef logic [127:0] rk_arr_t [1:10];
  typedef struct {
    logic [127:0] key;
    int           idx;
    logic [127:0] exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_a, start_b;
  logic [127:0]  key_a, key_b;
  logic          busy_a, busy_b, done_a, done_b;
  logic [1279:0] bus_a;
  logic [1023:0] bus_b;
`ifdef KEY_SCHED_STREAM_EN
  logic [127:0]  strm_a, strm_b;
  logic          strm_v_a, strm_v_b;
  logic [3:0]    strm_i_a, strm_i_b;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  aes_key_sched_iter #(.NUM_RK(10)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .key_in(key_a),
    .busy(busy_a), .done(done_a), .rk_bus(bus_a)
`ifdef KEY_SCHED_STREAM_EN
    , .rk_stream(strm_a), .rk_stream_v(strm_v_a), .rk_stream_i(strm_i_a)
`endif
  );

  aes_key_sched_iter #(.NUM_RK(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .key_in(key_b),
    .busy(busy_b), .done(done_b), .rk_bus(bus_b)
`ifdef KEY_SCHED_STREAM_EN
    , .rk_stream(strm_b), .rk_stream_v(strm_v_b), .rk_stream_i(strm_i_b)
`endif
  );

  // ---------------- reference model: FIPS-197 key expansion from field arithmetic
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    logic       hi;
    p = 8'h00; aa = a; bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      hi = aa[7];
      aa = aa << 1;
      if (hi) aa = aa ^ 8'h1b;
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    return (x << k) | (x >> (8 - k));
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h01;
    for (int k = 0; k < 254; k++) inv = gmul(inv, b);
    if (b == 8'h00) inv = 8'h00;
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  task automatic model_expand(input logic [127:0] key, output rk_arr_t rks);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_ref(tmp[31:24]), sbox_ref(tmp[23:16]), sbox_ref(tmp[15:8]), sbox_ref(tmp[7:0])};
        rc = 8'h01;
        for (int j = 1; j < i / 4; j++) rc = gmul(rc, 8'h02);
        tmp = tmp ^ {rc, 24'h0};
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 1; r <= 10; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- checking helpers
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] get_rk(input bit which, input int idx);
    if (which) return bus_b[(idx-1)*128 +: 128];
    return bus_a[(idx-1)*128 +: 128];
  endfunction

  // Drive one start pulse, then scramble key_in so late changes would be visible.
  task automatic begin_run(input bit which, input logic [127:0] key);
    if (which) begin start_b = 1'b1; key_b = key; end
    else       begin start_a = 1'b1; key_a = key; end
    tick();
    if (which) begin start_b = 1'b0; key_b = {$urandom, $urandom, $urandom, $urandom}; end
    else       begin start_a = 1'b0; key_a = {$urandom, $urandom, $urandom, $urandom}; end
  endtask

  // Called just after the start edge T; walks edges T+1..T+n+1.
  task automatic expand_check(input bit which, input string tag, input rk_arr_t exp);
    int n;
    n = which ? 8 : 10;
    chk1($sformatf("%s busy@T", tag), which ? busy_b : busy_a, 1'b1);
    chk1($sformatf("%s done@T", tag), which ? done_b : done_a, 1'b0);
    for (int i = 1; i <= n; i++) begin
      tick();
      chk($sformatf("%s rk%0d", tag, i), get_rk(which, i), exp[i]);
      chk1($sformatf("%s busy@T+%0d", tag, i), which ? busy_b : busy_a, i < n);
      chk1($sformatf("%s done@T+%0d", tag, i), which ? done_b : done_a, i == n);
`ifdef KEY_SCHED_STREAM_EN
      if (!which) begin
        chk1($sformatf("%s strm_v@T+%0d", tag, i), strm_v_a, 1'b1);
        chk($sformatf("%s strm_i@T+%0d", tag, i), {124'h0, strm_i_a}, 128'(i));
        chk($sformatf("%s strm@T+%0d", tag, i), strm_a, exp[i]);
      end
`endif
    end
    tick();
    chk1($sformatf("%s busy end", tag), which ? busy_b : busy_a, 1'b0);
    chk1($sformatf("%s done end", tag), which ? done_b : done_a, 1'b0);
`ifdef KEY_SCHED_STREAM_EN
    if (!which) chk1($sformatf("%s strm_v end", tag), strm_v_a, 1'b0);
`endif
  endtask

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  initial begin
    vec_t         vecs [4];
    rk_arr_t      exp, exp2;
    logic [127:0] k;

    vecs[0] = '{key: FIPS_KEY, idx: 1,  exp: 128'ha0fafe1788542cb123a339392a6c7605};
    vecs[1] = '{key: FIPS_KEY, idx: 2,  exp: 128'hf2c295f27a96b9435935807a7359f67f};
    vecs[2] = '{key: FIPS_KEY, idx: 10, exp: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[3] = '{key: 128'h0,   idx: 1,  exp: 128'h62636363626363636263636362636363};

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; key_a = '0; key_b = '0;
    tick(); tick();
    chk1("reset busy_a", busy_a, 1'b0);
    chk1("reset done_a", done_a, 1'b0);
    chk1("reset bus_a zero", bus_a == '0, 1'b1);
    chk1("reset busy_b", busy_b, 1'b0);
    chk1("reset bus_b zero", bus_b == '0, 1'b1);
`ifdef KEY_SCHED_STREAM_EN
    chk1("reset strm_v", strm_v_a, 1'b0);
    chk("reset strm", strm_a, 128'h0);
`endif
    rst = 1'b0;
    tick();

    // Known-answer table, each run also checked in full against the model.
    for (int v = 0; v < 4; v++) begin
      model_expand(vecs[v].key, exp);
      begin_run(1'b0, vecs[v].key);
      expand_check(1'b0, $sformatf("kat%0d", v), exp);
      chk($sformatf("kat%0d table rk%0d", v, vecs[v].idx), get_rk(1'b0, vecs[v].idx), vecs[v].exp);
    end

    // Bank holds after done while idle (zero key is the last run above).
    model_expand(128'h0, exp);
    repeat (5) tick();
    for (int i = 1; i <= 10; i++) chk($sformatf("hold rk%0d", i), get_rk(1'b0, i), exp[i]);

    // start held high with a different key: first run unaffected, second starts from IDLE.
    k = {$urandom, $urandom, $urandom, $urandom};
    model_expand(FIPS_KEY, exp);
    model_expand(k, exp2);
    start_a = 1'b1; key_a = FIPS_KEY;
    tick();
    key_a = k;
    expand_check(1'b0, "held1", exp);
    tick();
    start_a = 1'b0;
    expand_check(1'b0, "held2", exp2);

    // Reset during EXPAND aborts and clears; a fresh start then reproduces the FIPS keys.
    begin_run(1'b0, FIPS_KEY);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("abort busy", busy_a, 1'b0);
    chk1("abort done", done_a, 1'b0);
    chk1("abort bus zero", bus_a == '0, 1'b1);
    tick(); tick();
    chk1("abort no done later", done_a, 1'b0);
    model_expand(FIPS_KEY, exp);
    begin_run(1'b0, FIPS_KEY);
    expand_check(1'b0, "rerun", exp);

    // NUM_RK=8 instance.
    begin_run(1'b1, FIPS_KEY);
    expand_check(1'b1, "nrk8", exp);

    // Random keys against the model on both instances.
    for (int r = 0; r < 4; r++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      model_expand(k, exp);
      begin_run(1'b0, k);
      expand_check(1'b0, $sformatf("rnd%0d", r), exp);
      begin_run(1'b1, k);
      expand_check(1'b1, $sformatf("rnd8_%0d", r), exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
